data_mux_sched: RTL and testbench
=================================

Name: data_mux_sched

Overview:
- Round-robin burst scheduler for the 5-input registered data mux (din0..din4, 3-bit sel, one-cycle registered output).
- Arbitrates up to 5 requesters and drives the mux sel.
- Returns a per-beat ack to the winning source.
- Produces out_valid/out_src, delayed one cycle to line up with the mux's registered dout.

Parameters:
- NUM_SRC, 5, number of active requesters (legal 1..5); req bits at or above NUM_SRC are ignored.
- BURST_W, 4, width of burst_len and of the internal beat counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  scheduler run enable; low freezes all state.
- req  in  5  per-source request, level; bit i = din i has data.
- burst_len  in  BURST_W  beats per grant; sampled at grant; 0 treated as 1.
- sel  out  3  mux select, registered, drives mux sel directly.
- ack  out  5  one-hot, combinational; ack[i]=1 means din i is sampled by the mux at this edge.
- busy  out  1  registered; 1 while state=BURST.
- out_valid  out  1  registered; mux dout holds a scheduled beat this cycle.
- out_src  out  3  registered; source index of the beat currently on mux dout.

Behaviour:
- Reset values (async on rst_n low): sel=0, state=IDLE, busy=0, out_valid=0, out_src=0, beat counter=0, rr pointer=NUM_SRC-1 (so source 0 wins first). ack=0 follows from state=IDLE.
- FSM has two states, IDLE and BURST. Each rule below is evaluated only when enable=1.
- IDLE, any masked req set:
  - choose winner w = first set bit searching from ptr+1 upward, wrapping modulo NUM_SRC;
  - sel<=w, ptr<=w, cnt<=max(burst_len,1)-1, state<=BURST.
- IDLE, no req: stay in IDLE; sel holds its last value.
- ack[i] = (state==BURST) & (sel==i) & req[i] & enable.
- BURST with ack active (beat taken):
  - if cnt!=0: cnt<=cnt-1 and stay in BURST;
  - if cnt==0: end the burst and re-arbitrate in the same cycle using the IDLE rule, with ptr = the current source. A winner gives a back-to-back burst with no bubble; no requester gives state<=IDLE.
  - Re-arbitration includes the current source, which wins again only if it is the only requester.
- BURST with req[sel]=0 (source withdrew): no ack, burst aborted, state<=IDLE, ptr unchanged (already the aborted source). The next grant follows on the following cycle.
- Output timing: out_valid<=(ack!=0) and out_src<=sel on every edge with enable=1, i.e. exactly one cycle after the ack, matching mux dout.
- Latency: req rises in cycle t (IDLE) -> sel/ack in t+1 -> out_valid in t+2.
- enable=0:
  - ack=0; FSM, cnt, ptr and sel hold;
  - out_valid<=0 on each such edge.
  - On re-enable the burst resumes with the remaining beat count.
- sel is only ever 0..NUM_SRC-1; values 5..7 are never driven.
- Burst throughput: 1 beat/cycle while the source holds req.
- Reset mid-burst: immediate return to reset values; a partial burst is discarded, with no ack after reset.
- Simultaneous abort and cnt==0 is impossible, because an abort means no ack that cycle.

Optional Feature:
- Macro: DATA_MUX_SCHED_PRIO0_EN.
- Defined: source 0 is strict high priority at every arbitration point. If req[0]=1 it wins regardless of ptr, and ptr is not updated on a source-0 grant. Sources 1..NUM_SRC-1 round-robin among themselves. Bursts already in progress are never pre-empted.
- Undefined: pure round-robin over all sources as above.

Test Plan:
- Reset release, enable=1, req=5'b00100, burst_len=3:
  - sel=2 and ack=00100 for cycles 1..3 after req;
  - out_valid high for cycles 2..4 with out_src=2;
  - IDLE and busy=0 after the third beat.
- req=5'b11111 held, burst_len=1:
  - grant order 0,1,2,3,4,0 on consecutive cycles;
  - no bubble cycles, out_valid continuously 1.
- req=5'b00011, burst_len=2, then req[0] drops after its first beat:
  - one beat from source 0, abort, one idle cycle;
  - then 2 beats from source 1.
- burst_len=0 with req=5'b01000: exactly 1 beat from source 3 per grant; cnt never underflows.
- Mid-burst (burst_len=4), enable=0 for 3 cycles:
  - ack and out_valid are 0 during the freeze;
  - the remaining beats complete after re-enable, 4 beats total.
- With DATA_MUX_SCHED_PRIO0_EN defined, req=5'b10001 held, burst_len=2: source 0 repeatedly wins and source 4 is served only when req[0]=0. Without the macro, sources 0 and 4 alternate bursts.

Source files
------------

// File: rtl/data_mux_sched.sv
// Round-robin burst scheduler driving the select of a 5-input registered data mux.
// Optional build macro DATA_MUX_SCHED_PRIO0_EN makes source 0 strict high priority.
module data_mux_sched #(
  parameter int NUM_SRC = 5,
  parameter int BURST_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [4:0]         req,
  input  logic [BURST_W-1:0] burst_len,
  output logic [2:0]         sel,
  output logic [4:0]         ack,
  output logic               busy,
  output logic               out_valid,
  output logic [2:0]         out_src
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;

  localparam logic [4:0] SRC_MASK = 5'((32'd1 << NUM_SRC) - 32'd1);
  localparam logic [2:0] PTR_RST  = 3'(NUM_SRC - 1);

  logic [0:0]         state_q, state_d;
  logic [2:0]         sel_q, sel_d;
  logic [2:0]         ptr_q, ptr_d;
  logic [BURST_W-1:0] cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               out_valid_q, out_valid_d;
  logic [2:0]         out_src_q, out_src_d;

  logic [4:0] req_m;
  logic [4:0] cand;
  logic [4:0] above_ptr;
  logic [4:0] cand_hi;
  logic       win_found;
  logic [2:0] win_idx;
  logic       beat;
  logic       grant;

  function automatic logic [2:0] lowest_set(input logic [4:0] v);
    lowest_set = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (v[i]) lowest_set = 3'(i);
    end
  endfunction

  assign req_m = req & SRC_MASK;

  // Rotating priority: lowest requester strictly above ptr wins, else wrap to the lowest overall.
  always_comb begin
    cand      = req_m;
`ifdef DATA_MUX_SCHED_PRIO0_EN
    cand[0]   = 1'b0;
`endif
    above_ptr = ~(5'((6'd2 << ptr_q) - 6'd1));
    cand_hi   = cand & above_ptr;
    win_found = |cand;
    win_idx   = (|cand_hi) ? lowest_set(cand_hi) : lowest_set(cand);
`ifdef DATA_MUX_SCHED_PRIO0_EN
    if (req_m[0]) begin
      win_found = 1'b1;
      win_idx   = 3'd0;
    end
`endif
  end

  assign beat = enable && (state_q == BURST) && req_m[sel_q];
  assign ack  = beat ? (5'd1 << sel_q) : 5'd0;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    out_valid_d = 1'b0;
    out_src_d   = out_src_q;
    grant       = 1'b0;
    if (enable) begin
      out_valid_d = beat;
      out_src_d   = sel_q;
      if (state_q == IDLE) begin
        grant = win_found;
      end else if (beat) begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - BURST_W'(1);
        end else begin
          grant   = win_found;
          state_d = IDLE;
        end
      end else begin
        state_d = IDLE;
      end
      if (grant) begin
        state_d = BURST;
        sel_d   = win_idx;
        cnt_d   = (burst_len == '0) ? '0 : burst_len - BURST_W'(1);
`ifdef DATA_MUX_SCHED_PRIO0_EN
        if (win_idx != 3'd0) ptr_d = win_idx;
`else
        ptr_d   = win_idx;
`endif
      end
    end
    busy_d = (state_d == BURST);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= 3'd0;
      ptr_q       <= PTR_RST;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_src_q   <= 3'd0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_src_q   <= out_src_d;
    end
  end

  assign sel       = sel_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_src   = out_src_q;

endmodule

// File: tb/tb_data_mux_sched.sv
// Self-checking bench for data_mux_sched: beat-level reference model plus directed log checks.
module tb_data_mux_sched;

  localparam int NUM_SRC = 5;
  localparam int BURST_W = 4;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               en_i = 1'b0;
  logic [4:0]         req_i = '0;
  logic [BURST_W-1:0] bl_i = '0;
  logic [2:0]         sel_o;
  logic [4:0]         ack_o;
  logic               busy_o;
  logic               ov_o;
  logic [2:0]         os_o;

  int total = 0;
  int bad   = 0;

  data_mux_sched #(.NUM_SRC(NUM_SRC), .BURST_W(BURST_W)) dut (
    .clk(clk), .rst_n(rst_n), .enable(en_i), .req(req_i), .burst_len(bl_i),
    .sel(sel_o), .ack(ack_o), .busy(busy_o), .out_valid(ov_o), .out_src(os_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: current source, beats still owed in the burst, rr pointer.
  bit m_busy;
  int m_src, m_left, m_ptr, m_os;
  bit m_ov;

  function automatic int pick(input logic [4:0] r, input int p);
    logic [4:0] mr;
    mr = r & 5'((1 << NUM_SRC) - 1);
`ifdef DATA_MUX_SCHED_PRIO0_EN
    if (mr[0]) return 0;
    mr[0] = 1'b0;
`endif
    for (int k = 1; k <= NUM_SRC; k++) begin
      if (mr[(p + k) % NUM_SRC]) return (p + k) % NUM_SRC;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_src = 0; m_left = 0; m_ptr = NUM_SRC - 1; m_ov = 1'b0; m_os = 0;
  endtask

  bit log_en = 1'b0;
  int log_q[$];

  always @(negedge clk) begin
    logic [4:0] exp_ack;
    bit arb;
    int w;
    if (!rst_n) begin
      model_reset();
      check("rst_sel", sel_o, 0);
      check("rst_ack", ack_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_out_valid", ov_o, 0);
      check("rst_out_src", os_o, 0);
    end else begin
      exp_ack = (en_i && m_busy && req_i[m_src]) ? 5'(1 << m_src) : 5'd0;
      check("sel", sel_o, m_src);
      check("ack", ack_o, exp_ack);
      check("busy", busy_o, m_busy);
      check("out_valid", ov_o, m_ov);
      check("out_src", os_o, m_os);
      if (log_en) begin
        if (ov_o) log_q.push_back(os_o);
        else if (log_q.size() > 0) log_q.push_back(7);
      end
      if (en_i) begin
        m_ov = (exp_ack != 0);
        m_os = m_src;
        arb  = 1'b0;
        if (!m_busy) arb = 1'b1;
        else if (exp_ack != 0) begin
          m_left--;
          if (m_left == 0) begin m_busy = 1'b0; arb = 1'b1; end
        end else m_busy = 1'b0;
        if (arb) begin
          w = pick(req_i, m_ptr);
          if (w >= 0) begin
            m_busy = 1'b1;
            m_src  = w;
            m_left = (bl_i == 0) ? 1 : int'(bl_i);
`ifdef DATA_MUX_SCHED_PRIO0_EN
            if (w != 0) m_ptr = w;
`else
            m_ptr = w;
`endif
          end
        end
      end else begin
        m_ov = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_i = '0; en_i = 1'b1; bl_i = '0;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    log_q.delete();
  endtask

  task automatic check_log(input string name, input int exp_q[$]);
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s[%0d]", name, i), (log_q.size() > i) ? log_q[i] : 99, exp_q[i]);
  endtask

  // Reset, request pattern held for 'hold' edges, then all requests drop.
  task automatic run_held(input logic [4:0] r, input logic [BURST_W-1:0] bl, input int hold);
    do_reset();
    log_en = 1'b1;
    req_i = r; bl_i = bl;
    repeat (hold) tick();
    req_i = '0;
    repeat (4) tick();
    log_en = 1'b0;
  endtask

  initial begin
    int exp_q[$];
    tick(); tick();

    run_held(5'b00100, 4'd3, 4);
    exp_q = '{2, 2, 2, 7};
    check_log("single_src_burst3", exp_q);
    check("idle_busy_after_burst", busy_o, 0);

    run_held(5'b11111, 4'd1, 7);
    exp_q = '{0, 1, 2, 3, 4, 0, 7};
    check_log("all_req_rr_order", exp_q);

    do_reset();
    log_en = 1'b1;
    req_i = 5'b00011; bl_i = 4'd2;
    tick(); tick();
    req_i = 5'b00010;
    repeat (4) tick();
    req_i = '0;
    repeat (3) tick();
    log_en = 1'b0;
    exp_q = '{0, 7, 7, 1, 1, 7};
    check_log("abort_then_next", exp_q);

    run_held(5'b01000, 4'd0, 4);
    exp_q = '{3, 3, 3, 7};
    check_log("burst_len0_single", exp_q);
    run_held(5'b01001, 4'd0, 4);
    exp_q = '{0, 3, 0, 7};
    check_log("burst_len0_alternate", exp_q);

    do_reset();
    log_en = 1'b1;
    req_i = 5'b00001; bl_i = 4'd4;
    tick(); tick();
    en_i = 1'b0;
    tick();
    check("freeze_ack", ack_o, 0);
    check("freeze_out_valid", ov_o, 0);
    tick(); tick();
    en_i = 1'b1;
    repeat (3) tick();
    req_i = '0;
    repeat (3) tick();
    log_en = 1'b0;
    exp_q = '{0, 7, 7, 7, 0, 0, 0, 7};
    check_log("freeze_resume", exp_q);

    run_held(5'b10001, 4'd2, 9);
`ifdef DATA_MUX_SCHED_PRIO0_EN
    exp_q = '{0, 0, 0, 0, 0, 0, 0, 0};
`else
    exp_q = '{0, 0, 4, 4, 0, 0, 4, 4};
`endif
    check_log("src0_vs_src4", exp_q);

    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
      if ($urandom_range(0, 2) == 0) req_i = 5'($urandom);
      else if ($urandom_range(0, 5) == 0) req_i[$urandom_range(0, 4)] = 1'b0;
      if ($urandom_range(0, 7) == 0)
        bl_i = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 5));
      en_i = ($urandom_range(0, 9) != 0);
      tick();
    end
    rst_n = 1'b1;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
